// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access,
// with data priority. Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_size,
  output logic              if_done,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic              if_stall,
  output logic              d_stall,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } state_e;

  state_e      state_q;
  state_e      state_d;
  logic        grant_if_c;
  logic        grant_d_c;
  logic        timeout_c;
  logic [3:0]  d_be_c;

  // Byte enables for the data requester; size 11 falls back to a full word.
  always_comb begin
    d_be_c = 4'b1111;
    case (d_size)
      2'b01:   d_be_c = 4'b0001 << d_addr[1:0];
      2'b10:   d_be_c = d_addr[1] ? 4'b1100 : 4'b0011;
      default: d_be_c = 4'b1111;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration, completion pulses and read-data return; done is same-cycle as mem_ready.
  always_comb begin
    state_d    = state_q;
    grant_if_c = 1'b0;
    grant_d_c  = 1'b0;
    if_done    = 1'b0;
    d_done     = 1'b0;
    err        = 1'b0;
    rdata      = '0;
    case (state_q)
      IDLE: begin
        if (d_req) begin
          grant_d_c = 1'b1;
          state_d   = D_BUSY;
        end else if (if_req) begin
          grant_if_c = 1'b1;
          state_d    = IF_BUSY;
        end
      end
      IF_BUSY: begin
        if (mem_ready) begin
          if_done = 1'b1;
          rdata   = mem_rdata;
          state_d = IDLE;
        end else if (timeout_c) begin
          if_done = 1'b1;
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      D_BUSY: begin
        if (mem_ready) begin
          d_done  = 1'b1;
          rdata   = mem_rdata;
          state_d = IDLE;
        end else if (timeout_c) begin
          d_done  = 1'b1;
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_stall = if_req & ~if_done;
  assign d_stall  = d_req & ~d_done;

  // Memory-side request registers, loaded from the winner at grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'b0000;
    end else if (grant_d_c) begin
      mem_req   <= 1'b1;
      mem_we    <= d_we;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
      mem_be    <= d_be_c;
    end else if (grant_if_c) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= if_addr;
      mem_wdata <= '0;
      mem_be    <= 4'b1111;
    end else if (state_d == IDLE) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             busy_c;

  assign busy_c    = (state_q != IDLE);
  assign timeout_c = busy_c && !mem_ready && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Counts consecutive stalled busy cycles; restarts on every grant or completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (grant_d_c || grant_if_c || (state_d == IDLE)) begin
      cnt_q <= '0;
    end else if (busy_c && !mem_ready) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`else
  logic unused_timeout;

  assign timeout_c      = 1'b0;
  assign unused_timeout = TIMEOUT[0];
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; covers the watchdog variant when
// MEM_ARB_TIMEOUT_EN is defined for the build.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 16;

  logic              clk;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [1:0]        d_size;
  logic              if_done;
  logic              d_done;
  logic [DATA_W-1:0] rdata;
  logic              if_stall;
  logic              d_stall;
  logic              err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  int n_checks;
  int n_fail;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .if_done(if_done), .d_done(d_done), .rdata(rdata),
    .if_stall(if_stall), .d_stall(d_stall), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_size = 2'b00; mem_ready = 1'b0; mem_rdata = 32'h1234_5678;
    #3;
    n_checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_req: mem_req=%b mem_we=%b expected 0 0", mem_req, mem_we);
    end
    n_checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || mem_be !== 4'b0000) begin
      n_fail++; $display("FAIL reset_regs: addr=%h wdata=%h be=%b expected 0 0 0000", mem_addr, mem_wdata, mem_be);
    end
    n_checks++;
    if (if_done !== 1'b0 || d_done !== 1'b0 || err !== 1'b0 || rdata !== '0) begin
      n_fail++; $display("FAIL reset_outs: if_done=%b d_done=%b err=%b rdata=%h expected all 0", if_done, d_done, err, rdata);
    end
    #9 rst_n = 1'b1;
    step();
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: mem_req=%b expected 0", mem_req);
    end
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h100; mem_rdata = 32'hCAFE_F00D;
    #1;
    n_checks++;
    if (if_stall !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL fetch_pre: if_stall=%b mem_req=%b expected 1 0", if_stall, mem_req);
    end
    step();
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'b1111 || mem_addr !== 32'h100) begin
      n_fail++; $display("FAIL fetch_grant: req=%b we=%b be=%b addr=%h expected 1 0 1111 100", mem_req, mem_we, mem_be, mem_addr);
    end
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (if_done !== 1'b1 || d_done !== 1'b0 || rdata !== 32'hCAFE_F00D || if_stall !== 1'b0) begin
      n_fail++; $display("FAIL fetch_done: if_done=%b d_done=%b rdata=%h if_stall=%b expected 1 0 cafef00d 0", if_done, d_done, rdata, if_stall);
    end
    step();
    if_req = 1'b0; mem_ready = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || if_done !== 1'b0 || rdata !== '0) begin
      n_fail++; $display("FAIL fetch_after: mem_req=%b if_done=%b rdata=%h expected 0 0 0", mem_req, if_done, rdata);
    end
  endtask

  task automatic test_priority();
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h204; d_wdata = 32'hDEAD_BEEF; d_size = 2'b00;
    mem_rdata = 32'h0BAD_0BAD;
    step();
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h204 || mem_wdata !== 32'hDEAD_BEEF || mem_be !== 4'b1111) begin
      n_fail++; $display("FAIL prio_grant: req=%b we=%b addr=%h wdata=%h be=%b expected 1 1 204 deadbeef 1111", mem_req, mem_we, mem_addr, mem_wdata, mem_be);
    end
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (d_done !== 1'b1 || if_done !== 1'b0 || if_stall !== 1'b1 || d_stall !== 1'b0) begin
      n_fail++; $display("FAIL prio_done: d_done=%b if_done=%b if_stall=%b d_stall=%b expected 1 0 1 0", d_done, if_done, if_stall, d_stall);
    end
    step();
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || if_stall !== 1'b1) begin
      n_fail++; $display("FAIL prio_idle: mem_req=%b mem_we=%b if_stall=%b expected 0 0 1", mem_req, mem_we, if_stall);
    end
    step();
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40 || mem_be !== 4'b1111) begin
      n_fail++; $display("FAIL prio_fetch: req=%b we=%b addr=%h be=%b expected 1 0 40 1111", mem_req, mem_we, mem_addr, mem_be);
    end
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (if_done !== 1'b1 || rdata !== 32'h0BAD_0BAD) begin
      n_fail++; $display("FAIL prio_fetch_done: if_done=%b rdata=%h expected 1 0bad0bad", if_done, rdata);
    end
    step();
    if_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_byte_enable();
    logic [1:0]  sz  [8];
    logic [1:0]  ad  [8];
    logic [3:0]  be  [8];
    sz[0] = 2'b01; ad[0] = 2'd3; be[0] = 4'b1000;
    sz[1] = 2'b10; ad[1] = 2'd2; be[1] = 4'b1100;
    sz[2] = 2'b01; ad[2] = 2'd0; be[2] = 4'b0001;
    sz[3] = 2'b01; ad[3] = 2'd1; be[3] = 4'b0010;
    sz[4] = 2'b01; ad[4] = 2'd2; be[4] = 4'b0100;
    sz[5] = 2'b10; ad[5] = 2'd0; be[5] = 4'b0011;
    sz[6] = 2'b11; ad[6] = 2'd1; be[6] = 4'b1111;
    sz[7] = 2'b00; ad[7] = 2'd0; be[7] = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      d_req = 1'b1; d_we = 1'b0; d_size = sz[i]; d_addr = {28'h000_0300, 2'b00, ad[i]};
      mem_rdata = 32'hA000_0000 + 32'(i);
      step();
      n_checks++;
      if (mem_be !== be[i] || mem_we !== 1'b0 || mem_addr !== d_addr) begin
        n_fail++; $display("FAIL be_%0d: be=%b we=%b addr=%h expected %b 0 %h", i, mem_be, mem_we, mem_addr, be[i], d_addr);
      end
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if (d_done !== 1'b1 || rdata !== 32'hA000_0000 + 32'(i)) begin
        n_fail++; $display("FAIL be_done_%0d: d_done=%b rdata=%h expected 1 %h", i, d_done, rdata, 32'hA000_0000 + 32'(i));
      end
      step();
      d_req = 1'b0; mem_ready = 1'b0;
    end
  endtask

  task automatic test_no_abort();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_size = 2'b00; mem_rdata = 32'h5555_AAAA;
    step();
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h80;
    step();
    step();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h500 || if_stall !== 1'b1 || d_done !== 1'b0) begin
      n_fail++; $display("FAIL noabort_busy: req=%b addr=%h if_stall=%b d_done=%b expected 1 500 1 0", mem_req, mem_addr, if_stall, d_done);
    end
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (d_done !== 1'b1 || if_done !== 1'b0 || rdata !== 32'h5555_AAAA) begin
      n_fail++; $display("FAIL noabort_done: d_done=%b if_done=%b rdata=%h expected 1 0 5555aaaa", d_done, if_done, rdata);
    end
    step();
    mem_ready = 1'b0;
    step();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h80 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL late_fetch: req=%b addr=%h we=%b expected 1 80 0", mem_req, mem_addr, mem_we);
    end
    mem_ready = 1'b1;
    step();
    if_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h600; d_wdata = 32'h1111_2222; d_size = 2'b00;
    step();
    d_req = 1'b0;
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_grant: mem_req=%b mem_we=%b expected 1 1", mem_req, mem_we);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || d_done !== 1'b0 || mem_be !== 4'b0000 || mem_addr !== '0) begin
      n_fail++; $display("FAIL rstmid_async: req=%b we=%b d_done=%b be=%b addr=%h expected 0 0 0 0000 0", mem_req, mem_we, d_done, mem_be, mem_addr);
    end
    step();
    #2 rst_n = 1'b1;
    step();
    n_checks++;
    if (mem_req !== 1'b0 || d_done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_idle: mem_req=%b d_done=%b expected 0 0", mem_req, d_done);
    end
    if_req = 1'b1; if_addr = 32'h700;
    step();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h700 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_rearb: req=%b addr=%h we=%b expected 1 700 0", mem_req, mem_addr, mem_we);
    end
    mem_ready = 1'b1;
    step();
    if_req = 1'b0; mem_ready = 1'b0; d_we = 1'b0;
  endtask

  task automatic test_timeout();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h900; d_size = 2'b00;
    mem_ready = 1'b0; mem_rdata = 32'hFFFF_0000;
    step();
    d_req = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int c = 1; c < 16; c++) begin
      n_checks++;
      if (d_done !== 1'b0 || err !== 1'b0 || mem_req !== 1'b1) begin
        n_fail++; $display("FAIL tmo_wait_%0d: d_done=%b err=%b mem_req=%b expected 0 0 1", c, d_done, err, mem_req);
      end
      step();
    end
    n_checks++;
    if (d_done !== 1'b1 || err !== 1'b1 || rdata !== '0) begin
      n_fail++; $display("FAIL tmo_fire: d_done=%b err=%b rdata=%h expected 1 1 0", d_done, err, rdata);
    end
    step();
    n_checks++;
    if (mem_req !== 1'b0 || err !== 1'b0 || d_done !== 1'b0) begin
      n_fail++; $display("FAIL tmo_after: mem_req=%b err=%b d_done=%b expected 0 0 0", mem_req, err, d_done);
    end
`else
    for (int c = 1; c <= 110; c++) begin
      n_checks++;
      if (mem_req !== 1'b1 || err !== 1'b0 || d_done !== 1'b0) begin
        n_fail++; $display("FAIL notmo_%0d: mem_req=%b err=%b d_done=%b expected 1 0 0", c, mem_req, err, d_done);
      end
      step();
    end
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (d_done !== 1'b1 || err !== 1'b0 || rdata !== 32'hFFFF_0000) begin
      n_fail++; $display("FAIL notmo_done: d_done=%b err=%b rdata=%h expected 1 0 ffff0000", d_done, err, rdata);
    end
    step();
    mem_ready = 1'b0;
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_fetch();
    test_priority();
    test_byte_enable();
    test_no_abort();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time %0t exceeded bound", $time);
    $fatal(1, "bench time bound expired");
  end

endmodule
